// File: rtl/lfb_writer.sv
// Linear framebuffer writer: Wishbone CPU window to FML bridge with a 4-entry posted-write FIFO.
// Optional FML readback is enabled by defining LFB_READBACK_EN; otherwise reads return zero.
module lfb_writer #(
  parameter int                   fml_depth = 25,
  parameter logic [fml_depth-1:0] fb_base   = 25'h0A0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          start_addr,

  input  logic [15:0]          wb_adr_i,
  input  logic [15:0]          wb_dat_i,
  input  logic [1:0]           wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  output logic [15:0]          wb_dat_o,
  output logic                 wb_ack_o,

  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  output logic [1:0]           fml_sel,
  output logic [15:0]          fml_do,
  input  logic                 fml_ack,
  input  logic [15:0]          fml_di,

  output logic                 fifo_empty
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t               state_q;
  logic                 fml_stb_q;
  logic                 fml_we_q;
  logic [1:0]           fml_sel_q;
  logic [fml_depth-1:0] fml_adr_q;
  logic [15:0]          fml_do_q;
  logic                 wb_ack_q;
  logic [15:0]          wb_dat_q;

  logic [2:0]           count_q, count_d;
  logic [1:0]           wr_ptr_q, wr_ptr_d;
  logic [1:0]           rd_ptr_q, rd_ptr_d;
  logic [15:0]          fifo_adr_q [4];
  logic [15:0]          fifo_dat_q [4];
  logic [1:0]           fifo_sel_q [4];

  logic                 wb_req;
  logic                 wr_req;
  logic                 rd_req;
  logic                 push;
  logic                 pop;
  logic                 rd_accept;
  logic                 fml_ack_seen;

  // Byte address into FML; bit 0 is forced low because FML is 16-bit addressed.
  function automatic logic [fml_depth-1:0] fml_addr(input logic [15:0] word_adr);
    logic [fml_depth-1:0] sum;
    sum    = fb_base + fml_depth'({word_adr, 1'b0}) + fml_depth'(start_addr);
    sum[0] = 1'b0;
    return sum;
  endfunction

  assign wb_req       = wb_cyc_i & wb_stb_i;
  assign wr_req       = wb_req & wb_we_i;
  assign rd_req       = wb_req & ~wb_we_i;
  assign fml_ack_seen = fml_stb_q & fml_ack;

  // The full check uses the registered count, so a same-cycle pop cannot admit a push.
  assign push = wr_req & ~wb_ack_q & (count_q < 3'd4);
  assign pop  = (state_q == S_WR) & fml_ack_seen;

`ifdef LFB_READBACK_EN
  assign rd_accept = rd_req & ~wb_ack_q & (count_q == 3'd0) & (state_q == S_IDLE);
`else
  assign rd_accept = rd_req & ~wb_ack_q;
  logic unused_fml_di;
  assign unused_fml_di = ^fml_di;
`endif

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    if (push && !pop) begin
      count_d = count_q + 3'd1;
    end else if (pop && !push) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 3'd0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_adr_q[wr_ptr_q] <= wb_adr_i;
      fifo_dat_q[wr_ptr_q] <= wb_dat_i;
      fifo_sel_q[wr_ptr_q] <= wb_sel_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      fml_stb_q <= 1'b0;
      fml_we_q  <= 1'b0;
      fml_sel_q <= 2'b00;
      fml_adr_q <= '0;
      fml_do_q  <= 16'h0000;
      wb_ack_q  <= 1'b0;
      wb_dat_q  <= 16'h0000;
    end else begin
`ifdef LFB_READBACK_EN
      wb_ack_q <= push | ((state_q == S_RD) & fml_ack_seen);
`else
      wb_ack_q <= push | rd_accept;
      if (rd_accept) begin
        wb_dat_q <= 16'h0000;
      end
`endif
      unique case (state_q)
        S_IDLE: begin
          // Draining posted writes always wins over a waiting read.
          if (count_q != 3'd0) begin
            state_q   <= S_WR;
            fml_stb_q <= 1'b1;
            fml_we_q  <= 1'b1;
            fml_adr_q <= fml_addr(fifo_adr_q[rd_ptr_q]);
            fml_sel_q <= fifo_sel_q[rd_ptr_q];
            fml_do_q  <= fifo_dat_q[rd_ptr_q];
          end
`ifdef LFB_READBACK_EN
          else if (rd_accept) begin
            state_q   <= S_RD;
            fml_stb_q <= 1'b1;
            fml_we_q  <= 1'b0;
            fml_adr_q <= fml_addr(wb_adr_i);
            fml_sel_q <= 2'b11;
          end
`endif
        end
        S_WR: begin
          if (fml_ack_seen) begin
            state_q   <= S_IDLE;
            fml_stb_q <= 1'b0;
          end
        end
        S_RD: begin
          if (fml_ack_seen) begin
            state_q   <= S_IDLE;
            fml_stb_q <= 1'b0;
            wb_dat_q  <= fml_di;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          fml_stb_q <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ack_o   = wb_ack_q;
  assign wb_dat_o   = wb_dat_q;
  assign fml_stb    = fml_stb_q;
  assign fml_we     = fml_we_q;
  assign fml_sel    = fml_sel_q;
  assign fml_adr    = fml_adr_q;
  assign fml_do     = fml_do_q;
  assign fifo_empty = (count_q == 3'd0);

endmodule
